sr_cmd_debouncer: RTL and testbench

//   Front end that feeds the SR flip-flop stage. Takes two asynchronous, bouncy

---
 rtl/sr_cmd_debouncer.sv | 112 +++++++++++
 tb/tb_sr_cmd_debouncer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_debouncer.sv
// Set/clear command front end for the SR flip-flop stage.
// Each raw button input is synchronised, debounced and rising-edge detected.
// Simultaneous presses are arbitrated so s and r are never high together.

// One debounce channel: 2-flop synchroniser, consecutive-cycle counter, rise detect.
module sr_cmd_debouncer_chan #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: any agreement with the stable level restarts the count,
    // so bounce never accumulates toward a flip.
    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise     = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            rise     = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset clears synchroniser too, so a held input re-presses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module sr_cmd_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic conflict
);
    localparam int NUM_CH = 2;  // channel 0 = set, channel 1 = clear

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] rise;
    logic              s_q, s_d;
    logic              r_q, r_d;
    logic              conflict_q, conflict_d;

    assign raw = {clr_in, set_in};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sr_cmd_debouncer_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .raw_in(raw[g]),
            .rise  (rise[g])
        );
    end

    // Arbitration: clear wins a tie and the tie is flagged.
    always_comb begin
        s_d        = rise[0] & ~rise[1];
        r_d        = rise[1];
        conflict_d = rise[0] & rise[1];
    end

    // Registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Bench for sr_cmd_debouncer: directed scenarios plus random bursty inputs,
// compared cycle by cycle against a history-based reference model.
module tb_sr_cmd_debouncer;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_in = 1'b0;
    logic clr_in = 1'b0;
    logic s, r, conflict;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    int s_cnt = 0, r_cnt = 0, c_cnt = 0;
    int s_last = 0, r_last = 0, c_last = 0;

    // Reference model: per-channel delay queue (two sampling edges deep),
    // current debounced level, and length of the current run of disagreement.
    bit hist[2][$];
    bit m_stable[2];
    int m_run[2];

    sr_cmd_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .set_in  (set_in),
        .clr_in  (clr_in),
        .s       (s),
        .r       (r),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            hist[ch].delete();
            hist[ch].push_back(1'b0);
            hist[ch].push_back(1'b0);
            m_stable[ch] = 1'b0;
            m_run[ch]    = 0;
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, check outputs.
    task automatic step(input bit st, input bit cl, input bit rs);
        bit xin[2];
        bit rise[2];
        bit v;
        bit es, er, ec;
        set_in = st;
        clr_in = cl;
        rst    = rs;
        xin[0] = st;
        xin[1] = cl;
        @(posedge clk);
        edge_n++;
        if (rs) begin
            model_reset();
            rise[0] = 1'b0;
            rise[1] = 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                rise[ch] = 1'b0;
                v = hist[ch].pop_front();
                hist[ch].push_back(xin[ch]);
                if (v != m_stable[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D) begin
                        m_stable[ch] = v;
                        m_run[ch]    = 0;
                        rise[ch]     = v;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
        end
        es = rise[0] && !rise[1];
        er = rise[1];
        ec = rise[0] && rise[1];
        #1;
        chk("s", 32'(s), 32'(es));
        chk("r", 32'(r), 32'(er));
        chk("conflict", 32'(conflict), 32'(ec));
        chk("s_and_r", 32'(s & r), 32'd0);
        if (s === 1'b1)        begin s_cnt++; s_last = edge_n; end
        if (r === 1'b1)        begin r_cnt++; r_last = edge_n; end
        if (conflict === 1'b1) begin c_cnt++; c_last = edge_n; end
    endtask

    task automatic clr_counts();
        s_cnt = 0; r_cnt = 0; c_cnt = 0;
    endtask

    initial begin
        int k;
        int hs, hc;
        bit vs, vc, rs;
        model_reset();

        // 1: reset with both inputs high
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0);

        // 2: single press held, then released
        clr_counts();
        k = edge_n + 1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        chk("t2_s_count", 32'(s_cnt), 32'd1);
        chk("t2_s_latency", 32'(s_last - k), 32'd5);
        chk("t2_r_count", 32'(r_cnt + c_cnt), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        chk("t2_release_no_pulse", 32'(s_cnt), 32'd1);

        // 3: short clear glitch
        clr_counts();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        chk("t3_r_count", 32'(r_cnt), 32'd0);

        // 4: bounce then hold
        clr_counts();
        step(1'b1, 0, 0); step(1'b0, 0, 0); step(1'b1, 0, 0); step(1'b0, 0, 0);
        k = edge_n + 1;
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);
        chk("t4_s_count", 32'(s_cnt), 32'd1);
        chk("t4_s_latency", 32'(s_last - k), 32'd5);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

        // 5: simultaneous press, clear wins
        clr_counts();
        k = edge_n + 1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        chk("t5_s_count", 32'(s_cnt), 32'd0);
        chk("t5_r_count", 32'(r_cnt), 32'd1);
        chk("t5_c_count", 32'(c_cnt), 32'd1);
        chk("t5_r_latency", 32'(r_last - k), 32'd5);
        chk("t5_c_latency", 32'(c_last - k), 32'd5);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        chk("t5_release_pulses", 32'(s_cnt + r_cnt + c_cnt), 32'd2);

        // 6: reset mid-count with set held
        clr_counts();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("t6_no_pulse_before_rst", 32'(s_cnt), 32'd0);
        k = edge_n + 1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
        chk("t6_s_count", 32'(s_cnt), 32'd1);
        chk("t6_s_latency", 32'(s_last - k), 32'd5);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

        // Random bursty inputs with occasional resets
        hs = 0; hc = 0; vs = 0; vc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hs == 0) begin vs = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 9); end
            if (hc == 0) begin vc = 1'($urandom_range(0, 1)); hc = $urandom_range(1, 9); end
            hs--;
            hc--;
            rs = ($urandom_range(0, 59) == 0);
            step(vs, vc, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
